// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core.
// Contents: opcode/funct constants, 3-bit ALU control codes, the 4-bit FSM
// state enum (exported on the core's debug port), the datapath mux selects
// and the control word that the FSM hands to the datapath each cycle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctl_e;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,
        S_ADDIWB = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    typedef enum logic [0:0] {SRCA_PC, SRCA_A} srca_e;
    typedef enum logic [1:0] {SRCB_B, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2} srcb_e;
    typedef enum logic [1:0] {PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP} pcsrc_e;

    typedef struct packed {
        logic     mem_req;
        logic     mem_we;
        logic     iord;         // 1: memory address comes from ALUOut, 0: from PC
        logic     ir_we;
        logic     pc_we;        // unconditional PC write
        logic     branch;       // PC write qualified by ALU zero
        pcsrc_e   pc_src;
        logic     ab_we;
        srca_e    alu_src_a;
        srcb_e    alu_src_b;
        alu_ctl_e alu_ctl;
        logic     aluout_we;
        logic     mdr_we;
        logic     rf_we;
        logic     rf_dst_rd;    // 1: write rd, 0: write rt
        logic     rf_from_mdr;  // 1: write MDR, 0: write ALUOut
        logic     illegal;
    } ctrl_t;

    function automatic logic funct_legal(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_SLT);
    endfunction

    function automatic alu_ctl_e funct_to_alu(input logic [5:0] fn);
        alu_ctl_e c;
        case (fn)
            FN_SUB:  c = ALU_SUB;
            FN_AND:  c = ALU_AND;
            FN_OR:   c = ALU_OR;
            FN_SLT:  c = ALU_SLT;
            default: c = ALU_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_mc_control.sv
// FSM and control decode for the multicycle MIPS core.
// Ports:
//   clk, reset      - clock, synchronous active-low reset
//   opcode, funct   - fields of the current IR
//   mem_ready       - memory access completes this cycle
//   state           - current FSM state (debug)
//   ctrl            - control word for the datapath this cycle
// Memory handshake: the core holds mem_req with a stable address/write data
// until a cycle where mem_req && mem_ready; that cycle completes the access.
// mem_ready while mem_req is low is ignored.
module mips_mc_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output state_e     state,
    output ctrl_t      ctrl
);

    state_e state_q, state_d;
    // run_q is low for the cycle following any reset edge so that no memory
    // request is presented while reset is held or in the cycle it is taken.
    logic   run_q, run_d;

    assign state = state_q;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        run_d   = 1'b1;
        case (state_q)
            S_FETCH:  if (run_q && mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: state_d = funct_legal(funct) ? S_EXEC : S_FETCH;
                    OP_LW,
                    OP_SW:    state_d = S_MEMADR;
                    OP_ADDI:  state_d = S_ADDIEX;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode
    always_comb begin
        ctrl           = '0;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_ctl   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_req = run_q;
                ctrl.ir_we   = run_q && mem_ready;
                ctrl.pc_we   = run_q && mem_ready;
            end
            S_DECODE: begin
                ctrl.ab_we     = 1'b1;
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.aluout_we = 1'b1;
                ctrl.illegal   = !((opcode == OP_RTYPE && funct_legal(funct)) ||
                                   opcode == OP_LW || opcode == OP_SW ||
                                   opcode == OP_ADDI || opcode == OP_BEQ ||
                                   opcode == OP_J);
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.aluout_we = 1'b1;
            end
            S_MEMRD: begin
                ctrl.mem_req = run_q;
                ctrl.iord    = 1'b1;
                ctrl.mdr_we  = mem_ready;
            end
            S_MEMWB: begin
                ctrl.rf_we       = 1'b1;
                ctrl.rf_from_mdr = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req = run_q;
                ctrl.mem_we  = run_q;
                ctrl.iord    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_ctl   = funct_to_alu(funct);
                ctrl.aluout_we = 1'b1;
            end
            S_ALUWB: begin
                ctrl.rf_we     = 1'b1;
                ctrl.rf_dst_rd = 1'b1;
            end
            S_ADDIWB: ctrl.rf_we = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_ctl   = ALU_SUB;
                ctrl.branch    = 1'b1;
                ctrl.pc_src    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_we  = 1'b1;
                ctrl.pc_src = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core (add/sub/and/or/slt, lw, sw, beq, addi, j) with one
// shared ALU and a single memory port used for both fetch and data.
// Ports:
//   clk, reset         - clock, synchronous active-low reset
//   mem_req/mem_we     - access valid / access is a write
//   mem_addr           - word-aligned byte address (low ADDR_W bits)
//   mem_wdata          - store data
//   mem_rdata          - fetch/load data, valid with mem_ready
//   mem_ready          - access completes this cycle
//   pc                 - architectural PC
//   state              - FSM state (debug)
//   illegal            - one-cycle pulse in DECODE on an unsupported encoding
// The jump target assumes WIDTH == 32.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ready,
    output logic [WIDTH-1:0]  pc,
    output logic [3:0]        state,
    output logic              illegal
);

    ctrl_t  ctrl;
    state_e fsm_state;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] mdr_q, mdr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] aluout_q, aluout_d;

    logic [WIDTH-1:0] rf_q [32];
    logic [WIDTH-1:0] rs_val, rt_val;
    logic             rf_wr_en;
    logic [4:0]       rf_wr_addr;
    logic [WIDTH-1:0] rf_wr_data;

    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic             alu_zero;
    logic [WIDTH-1:0] addr_full;

    mips_mc_control u_control (
        .clk       (clk),
        .reset     (reset),
        .opcode    (ir_q[31:26]),
        .funct     (ir_q[5:0]),
        .mem_ready (mem_ready),
        .state     (fsm_state),
        .ctrl      (ctrl)
    );

    assign pc        = pc_q;
    assign state     = fsm_state;
    assign illegal   = ctrl.illegal;
    assign mem_req   = ctrl.mem_req;
    assign mem_we    = ctrl.mem_we;
    assign mem_wdata = b_q;
    // PC and ALUOut are held during waits, so the address is stable; the low
    // two bits are forced to zero to keep every access word aligned.
    assign addr_full = ctrl.iord ? aluout_q : pc_q;
    assign mem_addr  = ADDR_W'(addr_full & ~WIDTH'(3));

    assign imm_ext = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};

    // Register file: $0 is hard-wired to zero; contents survive reset.
    always_comb begin
        rs_val     = (ir_q[25:21] == 5'd0) ? '0 : rf_q[ir_q[25:21]];
        rt_val     = (ir_q[20:16] == 5'd0) ? '0 : rf_q[ir_q[20:16]];
        rf_wr_en   = ctrl.rf_we && (rf_wr_addr != 5'd0);
        rf_wr_addr = ctrl.rf_dst_rd ? ir_q[15:11] : ir_q[20:16];
        rf_wr_data = ctrl.rf_from_mdr ? mdr_q : aluout_q;
    end

    always_ff @(posedge clk) begin
        if (reset && rf_wr_en) begin
            rf_q[rf_wr_addr] <= rf_wr_data;
        end
    end

    // Shared ALU
    always_comb begin
        alu_a = (ctrl.alu_src_a == SRCA_PC) ? pc_q : a_q;
        case (ctrl.alu_src_b)
            SRCB_B:       alu_b = b_q;
            SRCB_FOUR:    alu_b = WIDTH'(4);
            SRCB_IMM:     alu_b = imm_ext;
            SRCB_IMM_SH2: alu_b = imm_ext << 2;
            default:      alu_b = b_q;
        endcase
        case (ctrl.alu_ctl)
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_ADD: alu_y = alu_a + alu_b;
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_SLT: alu_y = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_y = alu_a + alu_b;
        endcase
        alu_zero = (alu_y == '0);
    end

    // Datapath register next-state
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ctrl.ir_we ? mem_rdata : ir_q;
        mdr_d    = ctrl.mdr_we ? mem_rdata : mdr_q;
        a_d      = ctrl.ab_we ? rs_val : a_q;
        b_d      = ctrl.ab_we ? rt_val : b_q;
        aluout_d = ctrl.aluout_we ? alu_y : aluout_q;
        // BRANCH compares A-B on the ALU; ALUOut already holds the target
        // computed during DECODE.
        if (ctrl.pc_we || (ctrl.branch && alu_zero)) begin
            case (ctrl.pc_src)
                PCSRC_ALU:    pc_d = alu_y;
                PCSRC_ALUOUT: pc_d = aluout_q;
                PCSRC_JUMP:   pc_d = {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};
                default:      pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core. A memory model with programmable
// wait states serves the core; every completed access is checked in order
// against an expected queue filled when each test program is loaded.
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic        mem_ready;
    logic [3:0]  state;
    logic        illegal;

    logic [31:0] mem [256];
    logic [64:0] exp_q [$];      // {we, addr, wdata}
    int          f_cyc_q [$];    // cycle stamp of each completed fetch
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          wait_n = 0;
    bit          ready_idle = 1'b0;
    bit          block_writes = 1'b0;
    int          wr_count = 0;
    int          ill_count = 0;
    logic [31:0] load_pc;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    mips_multicycle_core #(
        .WIDTH    (32),
        .RESET_PC (32'h100),
        .ADDR_W   (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .state     (state),
        .illegal   (illegal)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic put(input logic [31:0] w);
        mem[load_pc[9:2]] = w;
        load_pc += 32'd4;
    endtask

    task automatic exp_rd(input logic [31:0] a);
        exp_q.push_back({1'b0, a, 32'h0});
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({1'b1, a, d});
    endtask

    task automatic chk_delta(input string name, input int i, input int j, input int exp);
        int d = -1;
        if (f_cyc_q.size() > j) d = f_cyc_q[j] - f_cyc_q[i];
        check(name, 32'(d), 32'(exp));
    endtask

    // Assert reset, then clear the model and queues once the core is idle.
    task automatic start_test(input int waits, input bit idle_rdy);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        f_cyc_q.delete();
        ill_count = 0;
        wr_count = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        wait_n = waits;
        ready_idle = idle_rdy;
        block_writes = 1'b0;
        load_pc = 32'h100;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- memory model + monitor ----------------
    initial begin : mem_model
        logic        done, pend, prev_ill;
        logic [31:0] p_addr, p_wdata;
        logic        p_we;
        logic [64:0] e;
        int          wcnt;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        pend = 1'b0;
        prev_ill = 1'b0;
        wcnt = 0;
        p_addr = 32'h0;
        p_wdata = 32'h0;
        p_we = 1'b0;
        forever begin
            @(negedge clk);
            done = mem_req && mem_ready;
            if (pend && mem_req) begin
                check("stable_addr", mem_addr, p_addr);
                check("stable_we", 32'(mem_we), 32'(p_we));
                if (p_we) check("stable_wdata", mem_wdata, p_wdata);
            end
            if (illegal) begin
                ill_count++;
                check("illegal_in_decode", 32'(state), 32'd1);
                check("illegal_one_cycle", 32'(prev_ill), 32'd0);
            end
            prev_ill = illegal;
            if (done) begin
                if (state == 4'd0) f_cyc_q.push_back(cyc);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("acc_we", 32'(mem_we), 32'(e[64]));
                    check("acc_addr", mem_addr, e[63:32]);
                    if (e[64]) check("acc_wdata", mem_wdata, e[31:0]);
                end
                if (mem_we) begin
                    mem[mem_addr[9:2]] = mem_wdata;
                    wr_count++;
                end
            end
            pend = mem_req && !mem_ready;
            p_addr = mem_addr;
            p_wdata = mem_wdata;
            p_we = mem_we;
            @(posedge clk);
            #1;
            cyc++;
            if (pend) wcnt++;
            else wcnt = 0;
            if (mem_req) mem_ready = (wcnt >= wait_n) && !(mem_we && block_writes);
            else mem_ready = ready_idle;
            mem_rdata = mem[mem_addr[9:2]];
        end
    end

    // ---------------- directed tests ----------------
    initial begin : main
        int n;

        // Reset behaviour and ALU ops with zero wait states; mem_ready is
        // left high while idle to show it is ignored.
        start_test(0, 1'b1);
        put(enc_i(6'h08, 0, 1, 16'd5));       // 100 addi $1,$0,5
        put(enc_i(6'h08, 0, 2, 16'hFFFD));    // 104 addi $2,$0,-3
        put(enc_r(1, 2, 3, 6'h20));           // 108 add  $3,$1,$2
        put(enc_i(6'h2B, 0, 3, 16'h0008));    // 10C sw   $3,8($0)
        put(enc_r(1, 2, 5, 6'h22));           // 110 sub  $5,$1,$2
        put(enc_i(6'h2B, 0, 5, 16'h0020));    // 114 sw   $5,0x20($0)
        put(enc_r(2, 1, 6, 6'h2A));           // 118 slt  $6,$2,$1
        put(enc_i(6'h2B, 0, 6, 16'h0024));    // 11C sw   $6,0x24($0)
        put(enc_r(1, 2, 9, 6'h2A));           // 120 slt  $9,$1,$2
        put(enc_i(6'h2B, 0, 9, 16'h0028));    // 124 sw   $9,0x28($0)
        put(enc_r(1, 2, 7, 6'h24));           // 128 and  $7,$1,$2
        put(enc_i(6'h2B, 0, 7, 16'h002C));    // 12C sw   $7,0x2C($0)
        put(enc_r(1, 2, 8, 6'h25));           // 130 or   $8,$1,$2
        put(enc_i(6'h2B, 0, 8, 16'h0030));    // 134 sw   $8,0x30($0)
        put(enc_i(6'h08, 0, 0, 16'd7));       // 138 addi $0,$0,7
        put(enc_i(6'h2B, 0, 0, 16'h0034));    // 13C sw   $0,0x34($0)
        put(enc_i(6'h04, 0, 0, 16'hFFFF));    // 140 beq  $0,$0,-1
        exp_rd(32'h100); exp_rd(32'h104); exp_rd(32'h108); exp_rd(32'h10C);
        exp_wr(32'h8, 32'd2);
        exp_rd(32'h110); exp_rd(32'h114); exp_wr(32'h20, 32'd8);
        exp_rd(32'h118); exp_rd(32'h11C); exp_wr(32'h24, 32'd1);
        exp_rd(32'h120); exp_rd(32'h124); exp_wr(32'h28, 32'd0);
        exp_rd(32'h128); exp_rd(32'h12C); exp_wr(32'h2C, 32'd5);
        exp_rd(32'h130); exp_rd(32'h134); exp_wr(32'h30, 32'hFFFFFFFD);
        exp_rd(32'h138); exp_rd(32'h13C); exp_wr(32'h34, 32'd0);
        exp_rd(32'h140); exp_rd(32'h140);
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 32'h100);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("first_req", 32'(mem_req), 32'd1);
        check("first_addr", mem_addr, 32'h100);
        wait_drain("a_drain", 300);
        chk_delta("a_addi_cycles", 0, 1, 4);
        chk_delta("a_rtype_cycles", 2, 3, 4);
        chk_delta("a_sw_cycles", 3, 4, 4);
        chk_delta("a_total_16", 0, 4, 16);
        chk_delta("a_beq_taken_cycles", 16, 17, 3);
        check("a_no_illegal", 32'(ill_count), 32'd0);

        // lw with two wait states on every access.
        start_test(2, 1'b0);
        mem[2] = 32'hDEADBEEF;
        put(enc_i(6'h23, 0, 4, 16'h0008));    // 100 lw  $4,8($0)
        put(enc_i(6'h2B, 0, 4, 16'h000C));    // 104 sw  $4,12($0)
        put(enc_i(6'h04, 0, 0, 16'hFFFF));    // 108 beq $0,$0,-1
        exp_rd(32'h100); exp_rd(32'h8); exp_rd(32'h104);
        exp_wr(32'hC, 32'hDEADBEEF);
        exp_rd(32'h108); exp_rd(32'h108);
        release_reset();
        wait_drain("b_drain", 300);
        chk_delta("b_lw_cycles_9", 0, 1, 9);
        chk_delta("b_sw_cycles_8", 1, 2, 8);
        check("b_mem_c", mem[3], 32'hDEADBEEF);

        // beq taken and not taken.
        start_test(0, 1'b0);
        put(enc_i(6'h08, 0, 1, 16'd9));       // 100 addi $1,$0,9
        put(enc_i(6'h04, 1, 1, 16'd2));       // 104 beq  $1,$1,2 -> 110
        put(enc_i(6'h08, 0, 2, 16'd1));       // 108 (skipped)
        put(enc_i(6'h08, 0, 2, 16'd2));       // 10C (skipped)
        put(enc_i(6'h04, 1, 0, 16'd5));       // 110 beq  $1,$0,5 not taken
        put(enc_i(6'h04, 0, 0, 16'hFFFF));    // 114 beq  $0,$0,-1
        exp_rd(32'h100); exp_rd(32'h104); exp_rd(32'h110);
        exp_rd(32'h114); exp_rd(32'h114);
        release_reset();
        wait_drain("c_drain", 200);
        chk_delta("c_beq_taken_3", 1, 2, 3);
        chk_delta("c_beq_not_taken_3", 2, 3, 3);

        // j 0x40 from 0x100 lands back on 0x100.
        start_test(0, 1'b0);
        put({6'h02, 26'h40});                 // 100 j 0x40
        exp_rd(32'h100); exp_rd(32'h100); exp_rd(32'h100);
        release_reset();
        wait_drain("d_drain", 200);
        chk_delta("d_j_cycles_3", 0, 1, 3);

        // Unsupported opcode and unsupported funct.
        start_test(0, 1'b0);
        put(32'hFC000000);                    // 100 opcode 0x3F
        put(enc_r(1, 1, 1, 6'h21));           // 104 R-type funct 0x21
        put(enc_i(6'h04, 0, 0, 16'hFFFF));    // 108 beq $0,$0,-1
        exp_rd(32'h100); exp_rd(32'h104); exp_rd(32'h108); exp_rd(32'h108);
        release_reset();
        wait_drain("e_drain", 200);
        check("e_illegal_count", 32'(ill_count), 32'd2);
        chk_delta("e_illegal_cycles", 0, 1, 2);

        // Reset during a stalled store: no write may commit.
        start_test(0, 1'b0);
        put(enc_i(6'h08, 0, 1, 16'h0055));    // 100 addi $1,$0,0x55
        put(enc_i(6'h2B, 0, 1, 16'h0040));    // 104 sw   $1,0x40($0)
        exp_rd(32'h100); exp_rd(32'h104);
        block_writes = 1'b1;
        release_reset();
        wait_drain("f_drain", 200);
        n = 0;
        while (state != 4'd5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("f_in_memwr", 32'(state), 32'd5);
        repeat (2) @(negedge clk);
        check("f_req_held", 32'(mem_req), 32'd1);
        check("f_we_held", 32'(mem_we), 32'd1);
        check("f_addr", mem_addr, 32'h40);
        check("f_wdata", mem_wdata, 32'h55);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("f_req_drops", 32'(mem_req), 32'd0);
        check("f_pc_reset", pc, 32'h100);
        repeat (2) @(negedge clk);
        check("f_no_write", 32'(wr_count), 32'd0);
        check("f_mem_untouched", mem[16], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Multicycle MIPS core and the parametrised successor to the single-cycle core. Each instruction runs over 3–5 FSM states with one shared ALU. Instruction and data traffic share one external memory port with a ready handshake, so memory may insert wait states. The block sits at the same level as the single-cycle top and drives the shared memory model or bus adapter.

## Interface
- `WIDTH`, 32: datapath and register width; only 32 is supported for the ISA, but internal buses use it.
- `RESET_PC`, 0: PC value loaded on reset.
- `ADDR_W`, 32: width of `mem_addr`; low `ADDR_W` bits of byte address.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: reset, synchronous, active-low.
- `mem_req` output 1: memory access valid this cycle.
- `mem_we` output 1: access is a write (only meaningful with `mem_req`).
- `mem_addr` output `ADDR_W`: byte address, word aligned.
- `mem_wdata` output `WIDTH`: store data.
- `mem_rdata` input `WIDTH`: load/fetch data, valid when `mem_ready`.
- `mem_ready` input 1: access completes this cycle.
- `pc` output `WIDTH`: current architectural PC.
- `state` output 4: FSM state encoding for debug.
- `illegal` output 1: one-cycle pulse on an unsupported opcode/funct.

## Operation
- ISA: R-type add, sub, and, or, slt; lw, sw, beq, addi, j.
- Unsupported encodings pulse `illegal`, retire as NOP, and advance to FETCH.
- Internal registers:
  - PC, IR, MDR, A, B, ALUOut.
  - Regfile is 32×`WIDTH`; $0 reads 0 and writes to it are ignored.
- FSM states and transitions:
  - FETCH: `mem_req`=1, addr=PC. Hold until `mem_ready`. On ready: IR←rdata, PC←PC+4, go to DECODE.
  - DECODE: A←rs, B←rt, ALUOut←PC+(signext(imm)<<2). Dispatch by opcode.
  - MEMADR: ALUOut←A+signext(imm). Next is MEMRD for lw or MEMWR for sw.
  - MEMRD: `mem_req`=1, addr=ALUOut. Hold until ready. Then MDR←rdata, go to MEMWB.
  - MEMWB: rt←MDR, go to FETCH.
  - MEMWR: `mem_req`=1, `mem_we`=1, wdata=B. Hold until ready, then go to FETCH.
  - EXEC: ALUOut←A op B, go to ALUWB. ALUWB: rd←ALUOut, go to FETCH.
  - ADDIEX: ALUOut←A+signext(imm), go to ADDIWB. ADDIWB: rt←ALUOut, go to FETCH.
  - BRANCH: if A==B then PC←ALUOut. Go to FETCH.
  - JUMP: PC←{PC[31:28], IR[25:0], 2'b00}. Go to FETCH.
- ALU: 3-bit control as in the existing control path. slt is a signed compare producing 0/1. add/sub wrap modulo 2^`WIDTH` with no overflow trap.
- `mem_addr`, `mem_we`, `mem_wdata` are stable while `mem_req` is high and `mem_ready` is low.
- `mem_addr[1:0]` is always 0.

## Timing
- On reset (`reset`=0 at a rising edge):
  - PC←`RESET_PC`, state←FETCH, IR/A/B/ALUOut/MDR←0.
  - `mem_req`=0, `mem_we`=0, `illegal`=0 for that cycle.
  - Regfile is not cleared.
- First fetch: `mem_req` asserts in the first cycle after reset is released.
- Cycles per instruction with zero wait states (`mem_ready` high whenever `mem_req` is high):
  - lw = 5; sw = 4; R-type = 4; addi = 4; beq = 3; j = 3.
- Each wait cycle adds exactly one cycle.
- Register writes take effect at the clock edge that leaves the WB state and are visible to the next DECODE.
- `illegal` is high for exactly the DECODE cycle.
- Reset asserted mid-access: `mem_req` drops in the next cycle and no write commits. The memory side must tolerate the abandoned request.
- `mem_ready` high while `mem_req` is low: ignored.

## Structure
- Shared package `mips_pkg`:
  - Opcode/funct constants.
  - ALU control codes.
  - State enum, 4-bit: FETCH=0 … JUMP=11.
- Sub-modules:
  - `mips_mc_control` holds the FSM and the decode of control signals.
  - The datapath stays in the top.
  - Reuse the existing ALU, regfile and sign-extend modules unchanged.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `RESET_PC`=0x100 → `pc`=0x100 and `mem_req`=0. In the first cycle after release, `mem_req`=1 and `mem_addr`=0x100.
- addi/add/sw, zero wait: run addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sw $3,8($0) → write to addr 8 with wdata=2. Total 16 cycles from the first fetch.
- lw with 2 wait states on every access: lw $4,8($0), where mem[8]=0xDEADBEEF → $4=0xDEADBEEF. 5+2+2=9 cycles. Address and data are stable across the waits.
- beq: taken with $1==$1 and offset 2 → next fetch at PC+4+8. Not taken → next fetch at PC+4. Each takes 3 cycles.
- j 0x40 at PC 0x100 → next fetch addr 0x100.
- Illegal and $0 handling: opcode 0x3F → `illegal` pulses for 1 cycle and the next fetch is at PC+4. addi $0,$0,7 → $0 still reads 0. Reset during MEMWR with `mem_ready`=0 → no write recorded.
